// File: rtl/su_rf_pkg.sv
// Shared types for the scalar register-file address sequencer.
// Holds the idle write code, bypass select encoding and pipeline entry layout.
package su_rf_pkg;

  localparam logic [15:0] REG_IDLE_W  = 16'h0000;
  localparam logic [15:0] REG_IDLE_WB = 16'hffff;

  typedef enum logic [1:0] {
    BYP_FILE = 2'd0,
    BYP_EX   = 2'd1,
    BYP_DF   = 2'd2
  } byp_sel_t;

  typedef struct packed {
    logic       valid;
    logic       wen;
    logic [4:0] dest;
  } pipe_t;

  localparam pipe_t PIPE_EMPTY = '{valid: 1'b0, wen: 1'b0, dest: 5'd0};

  // near holds the producer one slot ahead of the reader, far the one behind it
  function automatic byp_sel_t byp_calc(input logic [4:0] src, input pipe_t near,
                                        input pipe_t far);
    byp_sel_t sel;
    sel = BYP_FILE;
    if (src != 5'd0) begin
      if (near.valid && near.wen && near.dest == src) sel = BYP_EX;
      else if (far.valid && far.wen && far.dest == src) sel = BYP_DF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/su_rfdec_if.sv
// Issue-side inputs and register-file select outputs of the address sequencer.
// master drives instruction fields, slave (the sequencer) drives selects.
interface su_rfdec_if;
  logic        stall;
  logic        rd_valid;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  dest_addr;
  logic        dest_wen;
  logic        kill;
  logic [15:0] INST_RAL, INST_RALB, INST_RAH, INST_RAHB;
  logic [15:0] INST_RBL, INST_RBLB, INST_RBH, INST_RBHB;
  logic [15:0] INST_WL, INST_WLB, INST_WH, INST_WHB;
  logic [1:0]  byp_a;
  logic [1:0]  byp_b;
  logic        wb_pending;

  modport master (
    output stall, rd_valid, rs_addr, rt_addr, dest_addr, dest_wen, kill,
    input  INST_RAL, INST_RALB, INST_RAH, INST_RAHB,
    input  INST_RBL, INST_RBLB, INST_RBH, INST_RBHB,
    input  INST_WL, INST_WLB, INST_WH, INST_WHB,
    input  byp_a, byp_b, wb_pending
  );

  modport slave (
    input  stall, rd_valid, rs_addr, rt_addr, dest_addr, dest_wen, kill,
    output INST_RAL, INST_RALB, INST_RAH, INST_RAHB,
    output INST_RBL, INST_RBLB, INST_RBH, INST_RBHB,
    output INST_WL, INST_WLB, INST_WH, INST_WHB,
    output byp_a, byp_b, wb_pending
  );
endinterface

// File: rtl/su_rf_onehot_enc.sv
// 5-bit register specifier to dual-rail one-hot 16/16-split select vectors.
// Combinational; en=0 yields the idle code. Complement rails are derived, never driven separately.
module su_rf_onehot_enc
  import su_rf_pkg::*;
(
  input  logic [4:0]  addr,
  input  logic        en,
  output logic [15:0] l,
  output logic [15:0] lb,
  output logic [15:0] h,
  output logic [15:0] hb
);

  logic [15:0] bit_sel;

  assign bit_sel = 16'h0001 << addr[3:0];
  assign l       = (en && !addr[4]) ? bit_sel : REG_IDLE_W;
  assign h       = (en &&  addr[4]) ? bit_sel : REG_IDLE_W;
  assign lb      = ~l;
  assign hb      = ~h;

endmodule

// File: rtl/su_rfdec.sv
// Register-file address sequencer: read selects 1 cycle after RD, write strobe 3 cycles after RD.
// stall freezes every stage; kill squashes the EX entry as it moves to DF.
module su_rfdec
  import su_rf_pkg::*;
(
  input  logic       clk,
  input  logic       reset_l,
  su_rfdec_if.slave  rf
);

  pipe_t      ex_q, df_q, wb_q;
  logic [4:0] ra_q, rb_q;
  logic       w_en;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      ex_q <= PIPE_EMPTY;
      df_q <= PIPE_EMPTY;
      wb_q <= PIPE_EMPTY;
      ra_q <= 5'd0;
      rb_q <= 5'd0;
    end else if (!rf.stall) begin
      // r0 is hardwired, so its writes are dropped at capture
      ex_q <= '{valid: rf.rd_valid,
                wen:   rf.dest_wen && (rf.dest_addr != 5'd0),
                dest:  rf.dest_addr};
      df_q <= '{valid: ex_q.valid && !rf.kill, wen: ex_q.wen, dest: ex_q.dest};
      wb_q <= df_q;
      if (rf.rd_valid) begin
        ra_q <= rf.rs_addr;
        rb_q <= rf.rt_addr;
      end
    end
  end

  assign w_en = wb_q.valid && wb_q.wen;

  su_rf_onehot_enc u_enc_a (
    .addr (ra_q), .en (1'b1),
    .l (rf.INST_RAL), .lb (rf.INST_RALB), .h (rf.INST_RAH), .hb (rf.INST_RAHB)
  );

  su_rf_onehot_enc u_enc_b (
    .addr (rb_q), .en (1'b1),
    .l (rf.INST_RBL), .lb (rf.INST_RBLB), .h (rf.INST_RBH), .hb (rf.INST_RBHB)
  );

  su_rf_onehot_enc u_enc_w (
    .addr (wb_q.dest), .en (w_en),
    .l (rf.INST_WL), .lb (rf.INST_WLB), .h (rf.INST_WH), .hb (rf.INST_WHB)
  );

  // The reader's registered address lines up with its producer's EX result in the DF slot
  assign rf.byp_a      = byp_calc(ra_q, df_q, wb_q);
  assign rf.byp_b      = byp_calc(rb_q, df_q, wb_q);
  assign rf.wb_pending = (df_q.valid && df_q.wen) || w_en;

endmodule
